// File: rtl/cntb_sched.sv
// cntb_sched: in-order issue queue and sequencer for the shared CNTB bit-count
// datapath. It buffers XIF-issued CNTB instructions and launches the head entry
// once the core has committed it. Killed entries are dropped. Each result is
// returned on the XIF result channel with valid/ready handshaking.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a committed head; drops the head if it was killed
// S_START | one-cycle start pulse to the datapath
// S_WAIT  | datapath busy; operands held from the head entry
// S_RESP  | result presented on XIF; head popped when the result is taken
module cntb_sched #(
    parameter int         DEPTH  = 4,
    parameter int         ID_W   = 4,
    parameter logic [6:0] OPCODE = 7'h6b
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    output logic            issue_accept_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [31:0]     issue_rs0_i,
    input  logic [31:0]     issue_rs1_i,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            cntb_start_o,
    output logic [31:0]     cntb_word_o,
    output logic [4:0]      cntb_index_o,
    input  logic [4:0]      cntb_result_i,
    input  logic            cntb_done_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [31:0]     result_data_o,
    output logic            result_we_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0] ent_id    [DEPTH];
    logic [4:0]      ent_rd    [DEPTH];
    logic [31:0]     ent_word  [DEPTH];
    logic [4:0]      ent_index [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_comm;
    logic [DEPTH-1:0] ent_kill;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [4:0]       res_q;

    logic push;
    logic pop;
    logic head_ready;
    logic launched;
    logic in_resp;
    logic push_commit;

    // Instruction bits that the queue does not need.
    logic unused_bits;
    assign unused_bits = ^{issue_instr_i[31:12], issue_rs1_i[31:5]};

    // Count can only reach DEPTH (a power of two) when full, so its MSB is the full flag.
    assign issue_ready_o  = ~count[PTR_W];
    assign push           = issue_valid_i & issue_ready_o & (issue_instr_i[6:0] == OPCODE);
    assign issue_accept_o = push;
    assign push_commit    = commit_valid_i & (issue_id_i == commit_id_i);

    assign head_ready = ent_valid[head] & ent_comm[head];

    assign launched       = (state == S_START) || (state == S_WAIT);
    assign in_resp        = (state == S_RESP);
    assign cntb_start_o   = (state == S_START);
    assign cntb_word_o    = launched ? ent_word[head]  : '0;
    assign cntb_index_o   = launched ? ent_index[head] : '0;
    assign result_valid_o = in_resp;
    assign result_we_o    = in_resp;
    assign result_id_o    = in_resp ? ent_id[head] : '0;
    assign result_rd_o    = in_resp ? ent_rd[head] : '0;
    assign result_data_o  = in_resp ? {27'b0, res_q} : '0;

    // Next-state logic; pop is raised when a killed head is dropped or a result is taken.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_ready) begin
                    if (ent_kill[head]) pop = 1'b1;
                    else                state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (cntb_done_i) state_nxt = S_RESP;
            S_RESP: begin
                if (result_ready_i) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and captured datapath result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && cntb_done_i) res_q <= cntb_result_i;
        end
    end

    // Entry payload; only read while the entry is valid, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_id[tail]    <= issue_id_i;
            ent_rd[tail]    <= issue_instr_i[11:7];
            ent_word[tail]  <= issue_rs0_i;
            ent_index[tail] <= issue_rs1_i[4:0];
        end
    end

    // Entry flags, pointers and occupancy; a commit also tags the entry pushed this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid <= '0;
            ent_comm  <= '0;
            ent_kill  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (commit_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && (ent_id[i] == commit_id_i)) begin
                        ent_comm[i] <= 1'b1;
                        ent_kill[i] <= commit_kill_i;
                    end
                end
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_comm[tail]  <= push_commit;
                ent_kill[tail]  <= push_commit & commit_kill_i;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cntb_sched.sv
// Directed bench for cntb_sched: the bench plays the role of the core and of the
// datapath, and checks the queue ordering, commit/kill handling and result handshake.
module tb_cntb_sched;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam logic [6:0] OPC = 7'h6b;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic            issue_accept_o;
    logic [31:0]     issue_instr_i;
    logic [31:0]     issue_rs0_i;
    logic [31:0]     issue_rs1_i;
    logic [ID_W-1:0] issue_id_i;
    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;
    logic            cntb_start_o;
    logic [31:0]     cntb_word_o;
    logic [4:0]      cntb_index_o;
    logic [4:0]      cntb_result_i;
    logic            cntb_done_i;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [ID_W-1:0] result_id_o;
    logic [4:0]      result_rd_o;
    logic [31:0]     result_data_o;
    logic            result_we_o;

    int total = 0;
    int bad   = 0;

    cntb_sched #(.DEPTH(DEPTH), .ID_W(ID_W), .OPCODE(OPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_accept_o(issue_accept_o), .issue_instr_i(issue_instr_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i), .issue_id_i(issue_id_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .cntb_start_o(cntb_start_o), .cntb_word_o(cntb_word_o), .cntb_index_o(cntb_index_o),
        .cntb_result_i(cntb_result_i), .cntb_done_i(cntb_done_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .result_data_o(result_data_o), .result_we_o(result_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic [ID_W-1:0] id, input logic [4:0] rd, input logic [6:0] opc,
                            input logic [31:0] w, input logic [31:0] r1, output logic acc);
        issue_valid_i = 1'b1;
        issue_instr_i = {20'h0, rd, opc};
        issue_rs0_i   = w;
        issue_rs1_i   = r1;
        issue_id_i    = id;
        #1;
        acc = issue_accept_o;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [ID_W-1:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    // Datapath model: wait for start, hold two cycles, then return res with done.
    task automatic run_op(input logic [4:0] res, output logic got, output logic [31:0] w,
                          output logic [4:0] idx, output logic start_next, output logic [31:0] w_done);
        got = 1'b0; w = '0; idx = '0; start_next = 1'b0; w_done = '0;
        for (int n = 0; n < 20; n++) begin
            if (cntb_start_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            w   = cntb_word_o;
            idx = cntb_index_o;
            tick();
            start_next = cntb_start_o;
            tick();
            cntb_done_i   = 1'b1;
            cntb_result_i = res;
            w_done        = cntb_word_o;
            tick();
            cntb_done_i   = 1'b0;
            cntb_result_i = '0;
        end
    endtask

    task automatic pop_result(output logic got, output logic [ID_W-1:0] id, output logic [4:0] rd,
                              output logic [31:0] data, output logic we);
        got = 1'b0; id = '0; rd = '0; data = '0; we = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (result_valid_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            id = result_id_o; rd = result_rd_o; data = result_data_o; we = result_we_o;
            result_ready_i = 1'b1;
            tick();
            result_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        total++;
        if ({issue_ready_o, issue_accept_o, cntb_start_o, result_valid_o, result_we_o} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got %b exp 10000",
                     {issue_ready_o, issue_accept_o, cntb_start_o, result_valid_o, result_we_o});
        end
        total++;
        if ({cntb_word_o, cntb_index_o} !== 37'd0) begin
            bad++;
            $display("FAIL reset_datapath: got %h exp 0", {cntb_word_o, cntb_index_o});
        end
        total++;
        if ({result_id_o, result_rd_o, result_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_result: got %h exp 0", {result_id_o, result_rd_o, result_data_o});
        end
    endtask

    task automatic test_single();
        logic acc, got, sn, we;
        logic [31:0] w, wd, data;
        logic [4:0] idx, rd;
        logic [ID_W-1:0] id;
        do_issue(4'd3, 5'd5, OPC, 32'hF0F0_00FF, 32'd8, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL single_accept: got %b exp 1", acc); end
        do_commit(4'd3, 1'b0);
        run_op(5'd12, got, w, idx, sn, wd);
        total++;
        if ({got, w, idx} !== {1'b1, 32'hF0F0_00FF, 5'd8}) begin
            bad++;
            $display("FAIL single_start: got %b %h %0d exp 1 f0f000ff 8", got, w, idx);
        end
        total++;
        if ({sn, wd} !== {1'b0, 32'hF0F0_00FF}) begin
            bad++;
            $display("FAIL single_pulse_hold: got start=%b word=%h exp 0 f0f000ff", sn, wd);
        end
        pop_result(got, id, rd, data, we);
        total++;
        if ({got, id, rd, data, we} !== {1'b1, 4'd3, 5'd5, 32'd12, 1'b1}) begin
            bad++;
            $display("FAIL single_result: got v=%b id=%0d rd=%0d data=%0d we=%b exp 1 3 5 12 1",
                     got, id, rd, data, we);
        end
        total++;
        if ({result_valid_o, issue_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL single_after: got %b exp 01", {result_valid_o, issue_ready_o});
        end
    endtask

    task automatic test_kill();
        logic acc, got, sn, we;
        logic [31:0] w, wd, data;
        logic [4:0] idx, rd;
        logic [ID_W-1:0] id;
        int extra;
        do_issue(4'd1, 5'd1, OPC, 32'hAAAA_AAAA, 32'd1, acc);
        do_issue(4'd2, 5'd2, OPC, 32'h5555_0000, 32'd2, acc);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        run_op(5'd7, got, w, idx, sn, wd);
        total++;
        if ({got, w, idx} !== {1'b1, 32'h5555_0000, 5'd2}) begin
            bad++;
            $display("FAIL kill_first_start: got %b %h %0d exp 1 55550000 2", got, w, idx);
        end
        pop_result(got, id, rd, data, we);
        total++;
        if ({got, id, rd, data} !== {1'b1, 4'd2, 5'd2, 32'd7}) begin
            bad++;
            $display("FAIL kill_result: got v=%b id=%0d rd=%0d data=%0d exp 1 2 2 7", got, id, rd, data);
        end
        extra = 0;
        for (int n = 0; n < 10; n++) begin
            if (cntb_start_o || result_valid_o) extra++;
            tick();
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL kill_extra_activity: got %0d exp 0", extra); end
    endtask

    task automatic test_full_wrap();
        logic acc, got, sn, we;
        logic [31:0] w, wd, data;
        logic [4:0] idx, rd;
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] e_id;
        logic [4:0] e_rd, e_res;
        logic [31:0] e_w;
        int stall_err;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < DEPTH; k++) begin
                e_id = ID_W'(4 + b * 4 + k);
                e_rd = 5'(k + 1 + b * 8);
                e_w  = 32'hA000_0000 | 32'(b * 4 + k);
                do_issue(e_id, e_rd, OPC, e_w, 32'(k + 16), acc);
            end
            if (b == 0) begin
                total++;
                if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b exp 0", issue_ready_o); end
                do_issue(4'd15, 5'd31, OPC, 32'hDEAD_BEEF, 32'd0, acc);
                total++;
                if (acc !== 1'b0) begin bad++; $display("FAIL full_reject: got %b exp 0", acc); end
            end
            for (int k = DEPTH - 1; k >= 0; k--) do_commit(ID_W'(4 + b * 4 + k), 1'b0);
            for (int k = 0; k < DEPTH; k++) begin
                e_id  = ID_W'(4 + b * 4 + k);
                e_rd  = 5'(k + 1 + b * 8);
                e_w   = 32'hA000_0000 | 32'(b * 4 + k);
                e_res = 5'(b * 4 + k + 1);
                run_op(e_res, got, w, idx, sn, wd);
                total++;
                if ({got, w, idx} !== {1'b1, e_w, 5'(k + 16)}) begin
                    bad++;
                    $display("FAIL wrap_start b%0d k%0d: got %b %h %0d exp 1 %h %0d", b, k, got, w, idx, e_w, k + 16);
                end
                if (b == 0 && k == 0) begin
                    stall_err = 0;
                    for (int n = 0; n < 5; n++) begin
                        if ({result_valid_o, result_id_o, result_rd_o, result_data_o} !==
                            {1'b1, e_id, e_rd, {27'b0, e_res}}) stall_err++;
                        tick();
                    end
                    total++;
                    if (stall_err !== 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles exp 0", stall_err); end
                end
                pop_result(got, id, rd, data, we);
                total++;
                if ({got, id, rd, data} !== {1'b1, e_id, e_rd, {27'b0, e_res}}) begin
                    bad++;
                    $display("FAIL wrap_result b%0d k%0d: got v=%b id=%0d rd=%0d data=%0d exp 1 %0d %0d %0d",
                             b, k, got, id, rd, data, e_id, e_rd, e_res);
                end
            end
        end
    endtask

    task automatic test_foreign();
        logic acc;
        int starts;
        do_issue(4'd9, 5'd3, 7'h33, 32'h1234_5678, 32'd4, acc);
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL foreign_accept: got %b exp 0", acc); end
        do_commit(4'd9, 1'b0);
        starts = 0;
        for (int n = 0; n < 6; n++) begin
            if (cntb_start_o) starts++;
            tick();
        end
        total++;
        if ({dut.count, issue_ready_o, 32'(starts)} !== {3'd0, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL foreign_state: got count=%0d ready=%b starts=%0d exp 0 1 0", dut.count, issue_ready_o, starts);
        end
    endtask

    task automatic test_same_cycle_commit();
        logic got, sn, we;
        logic [31:0] w, wd, data;
        logic [4:0] idx, rd;
        logic [ID_W-1:0] id;
        issue_valid_i = 1'b1; issue_instr_i = {20'h0, 5'd9, OPC};
        issue_rs0_i = 32'h0000_F00F; issue_rs1_i = 32'd3; issue_id_i = 4'd6;
        commit_valid_i = 1'b1; commit_id_i = 4'd6; commit_kill_i = 1'b0;
        tick();
        issue_valid_i = 1'b0; commit_valid_i = 1'b0;
        run_op(5'd4, got, w, idx, sn, wd);
        pop_result(got, id, rd, data, we);
        total++;
        if ({got, id, rd, data} !== {1'b1, 4'd6, 5'd9, 32'd4}) begin
            bad++;
            $display("FAIL same_cycle_commit: got v=%b id=%0d rd=%0d data=%0d exp 1 6 9 4", got, id, rd, data);
        end
    endtask

    task automatic test_reset_in_wait();
        logic acc;
        int seen;
        do_issue(4'd5, 5'd7, OPC, 32'hFFFF_FFFF, 32'd0, acc);
        do_commit(4'd5, 1'b0);
        for (int n = 0; n < 20 && !cntb_start_o; n++) tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cntb_done_i = 1'b1; cntb_result_i = 5'd9;
        tick();
        cntb_done_i = 1'b0; cntb_result_i = '0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            if (result_valid_o || cntb_start_o) seen++;
            tick();
        end
        total++;
        if ({32'(seen), dut.count, issue_ready_o} !== {32'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_wait: got activity=%0d count=%0d ready=%b exp 0 0 1", seen, dut.count, issue_ready_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs0_i = '0; issue_rs1_i = '0;
        issue_id_i = '0; commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        cntb_result_i = '0; cntb_done_i = 1'b0; result_ready_i = 1'b0;
        test_reset();
        test_single();
        test_kill();
        test_full_wrap();
        test_foreign();
        test_same_cycle_commit();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
